// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC owner: issues instruction-memory requests, applies exc/branch/jump
// redirects and fills the IF/ID register under decode stall control.
module fetch_pc_ctrl #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h8000_0180)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [WIDTH-1:0] ifid_pc,
  output logic [WIDTH-1:0] ifid_pc4,
  output logic [31:0]      ifid_instr,
  output logic             misalign
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HELD} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             imem_req_q;
  logic             ifid_valid_q;
  logic [WIDTH-1:0] ifid_pc_q;
  logic [WIDTH-1:0] ifid_pc4_q;
  logic [31:0]      ifid_instr_q;
  logic             misalign_q;
  logic             pend_vld_q;
  logic             pend_exc_q;
  logic [WIDTH-1:0] pend_tgt_q;
  logic [WIDTH-1:0] hold_pc_q;
  logic [WIDTH-1:0] hold_pc4_q;
  logic [31:0]      hold_instr_q;

  logic             redir;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] new_tgt;
  logic             keep_pend;
  logic             eff_vld;
  logic             eff_exc;
  logic [WIDTH-1:0] eff_tgt;

  assign redir = exc | br_taken | jmp;

  always_comb begin
    raw_tgt = jmp_target;
    if (exc)           raw_tgt = EXC_VEC;
    else if (br_taken) raw_tgt = br_target;
  end

  assign new_tgt = {raw_tgt[WIDTH-1:2], 2'b00};

  // A pending exception is never displaced by a later branch or jump.
  assign keep_pend = pend_vld_q & pend_exc_q & ~exc;
  assign eff_vld   = redir | pend_vld_q;
  assign eff_exc   = exc | (pend_vld_q & pend_exc_q);
  assign eff_tgt   = (keep_pend | ~redir) ? pend_tgt_q : new_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_VEC;
      imem_req_q   <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      misalign_q   <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_exc_q   <= 1'b0;
      pend_tgt_q   <= '0;
      hold_pc_q    <= '0;
      hold_pc4_q   <= '0;
      hold_instr_q <= '0;
    end else begin
      misalign_q <= redir & (raw_tgt[1:0] != 2'b00);
      case (state_q)
        S_ISSUE: begin
          state_q    <= S_WAIT;
          imem_req_q <= 1'b1;
          if (eff_vld) begin
            pend_vld_q   <= 1'b1;
            pend_exc_q   <= eff_exc;
            pend_tgt_q   <= eff_tgt;
            ifid_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            if (eff_vld) begin
              // Fetched word belongs to the abandoned path; drop it.
              pc_q         <= eff_tgt;
              pend_vld_q   <= 1'b0;
              pend_exc_q   <= 1'b0;
              ifid_valid_q <= 1'b0;
              state_q      <= S_ISSUE;
              imem_req_q   <= 1'b1;
            end else if (stall) begin
              hold_pc_q    <= pc_q;
              hold_pc4_q   <= pc_plus4;
              hold_instr_q <= imem_rdata;
              state_q      <= S_HELD;
              imem_req_q   <= 1'b0;
            end else begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= pc_q;
              ifid_pc4_q   <= pc_plus4;
              ifid_instr_q <= imem_rdata;
              pc_q         <= pc_plus4;
              state_q      <= S_ISSUE;
              imem_req_q   <= 1'b1;
            end
          end else if (eff_vld) begin
            pend_vld_q   <= 1'b1;
            pend_exc_q   <= eff_exc;
            pend_tgt_q   <= eff_tgt;
            ifid_valid_q <= 1'b0;
          end
        end
        S_HELD: begin
          if (redir) begin
            pc_q         <= new_tgt;
            ifid_valid_q <= 1'b0;
            state_q      <= S_ISSUE;
            imem_req_q   <= 1'b1;
          end else if (!stall) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= hold_pc_q;
            ifid_pc4_q   <= hold_pc4_q;
            ifid_instr_q <= hold_instr_q;
            pc_q         <= pc_plus4;
            state_q      <= S_ISSUE;
            imem_req_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_ISSUE;
          imem_req_q <= 1'b1;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic against a
// transaction-level reference of the fetch/redirect rules.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RVEC = 32'h0000_0000;
  localparam logic [31:0] EVEC = 32'h8000_0180;
  localparam int PH_ISSUE = 0, PH_WAIT = 1, PH_HELD = 2;

  logic        clk, rst;
  logic [31:0] pc_plus4, pc;
  logic        stall, br_taken, jmp, exc;
  logic [31:0] br_target, jmp_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid, misalign;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference state
  int          m_ph;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_iins, m_pt, m_hpc, m_hins;
  logic        m_req, m_iv, m_mis, m_pv, m_pe;

  fetch_pc_ctrl #(.WIDTH(32), .RESET_VEC(RVEC), .EXC_VEC(EVEC)) dut (
    .clk(clk), .rst(rst), .pc_plus4(pc_plus4), .pc(pc), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .exc(exc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered PC+4 adder feeding the DUT
  always @(posedge clk) pc_plus4 <= pc + 32'd4;

  task automatic model_step();
    logic redir;
    logic [31:0] raw, tgt;
    if (rst) begin
      m_ph = PH_ISSUE; m_pc = RVEC; m_req = 0; m_iv = 0; m_ipc = 0; m_ipc4 = 0;
      m_iins = 0; m_mis = 0; m_pv = 0; m_pe = 0; m_pt = 0; m_hpc = 0; m_hins = 0;
    end else begin
      redir = exc | br_taken | jmp;
      raw   = exc ? EVEC : (br_taken ? br_target : jmp_target);
      tgt   = raw & ~32'h3;
      m_mis = redir && (raw[1:0] != 2'b00);
      if (m_ph == PH_HELD) begin
        if (redir) begin
          m_pc = tgt; m_iv = 0; m_ph = PH_ISSUE;
        end else if (!stall) begin
          m_iv = 1; m_ipc = m_hpc; m_ipc4 = m_hpc + 4; m_iins = m_hins;
          m_pc = m_pc + 4; m_ph = PH_ISSUE;
        end
      end else begin
        if (redir) begin
          m_iv = 0;
          if (!(m_pv && m_pe) || exc) begin m_pv = 1; m_pe = exc; m_pt = tgt; end
        end
        if (m_ph == PH_WAIT && imem_ack) begin
          if (m_pv) begin
            m_pc = m_pt; m_pv = 0; m_pe = 0; m_iv = 0; m_ph = PH_ISSUE;
          end else if (stall) begin
            m_hpc = m_pc; m_hins = imem_rdata; m_ph = PH_HELD;
          end else begin
            m_iv = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_iins = imem_rdata;
            m_pc = m_pc + 4; m_ph = PH_ISSUE;
          end
        end else begin
          m_ph = PH_WAIT;
        end
      end
      m_req = (m_ph != PH_HELD);
    end
  endtask

  task automatic clr_in();
    rst = 0; stall = 0; br_taken = 0; jmp = 0; exc = 0; imem_ack = 0;
    br_target = 0; jmp_target = 0; imem_rdata = 0;
  endtask

  // advance one clock; inputs change and outputs are sampled at negedge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic fetch_one(input logic [31:0] d);
    imem_ack = 0; tick();
    imem_ack = 1; imem_rdata = d; tick();
    imem_ack = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (pc !== RVEC) begin err_cnt++; $display("FAIL reset_pc got %h exp %h", pc, RVEC); end
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req got %b exp 0", imem_req); end
    vec_cnt++; if (ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    vec_cnt++; if ({ifid_pc, ifid_pc4, ifid_instr} !== 96'h0) begin err_cnt++; $display("FAIL reset_ifid got %h/%h/%h exp 0", ifid_pc, ifid_pc4, ifid_instr); end
    vec_cnt++; if (misalign !== 1'b0) begin err_cnt++; $display("FAIL reset_misalign got %b exp 0", misalign); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 32'hA000_0000 + i;
      imem_ack = 0; tick();
      vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'(i*4)) begin err_cnt++; $display("FAIL seq_req[%0d] got %b/%h exp 1/%h", i, imem_req, imem_addr, i*4); end
      imem_ack = 1; imem_rdata = d; tick(); imem_ack = 0;
      vec_cnt++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(i*4) || ifid_pc4 !== 32'(i*4+4) || ifid_instr !== d) begin
        err_cnt++; $display("FAIL seq_ifid[%0d] got %b/%h/%h/%h exp 1/%h/%h/%h", i, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, i*4, i*4+4, d); end
      vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL seq_req_hi[%0d] got %b exp 1", i, imem_req); end
    end
  endtask

  task automatic test_stall_on_ack();
    do_reset();
    fetch_one(32'h1111_0000); fetch_one(32'h1111_0004);
    tick();
    stall = 1; imem_ack = 1; imem_rdata = 32'h1111_0008; tick(); imem_ack = 0;
    vec_cnt++; if (imem_req !== 1'b0 || ifid_pc !== 32'h4 || pc !== 32'h8) begin err_cnt++; $display("FAIL stall_held got req=%b ifid_pc=%h pc=%h exp 0/4/8", imem_req, ifid_pc, pc); end
    tick();
    vec_cnt++; if (imem_req !== 1'b0 || ifid_instr !== 32'h1111_0004) begin err_cnt++; $display("FAIL stall_hold got req=%b instr=%h exp 0/11110004", imem_req, ifid_instr); end
    stall = 0; tick();
    vec_cnt++; if (ifid_pc !== 32'h8 || ifid_pc4 !== 32'hC || ifid_instr !== 32'h1111_0008 || ifid_valid !== 1'b1) begin
      err_cnt++; $display("FAIL stall_release got %b/%h/%h/%h exp 1/8/c/11110008", ifid_valid, ifid_pc, ifid_pc4, ifid_instr); end
    vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin err_cnt++; $display("FAIL stall_next got %b/%h exp 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    for (int i = 0; i < 4; i++) fetch_one(32'h2000_0000 + i);
    tick();
    br_taken = 1; br_target = 32'h100; tick(); br_taken = 0;
    vec_cnt++; if (ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL br_valid got %b exp 0", ifid_valid); end
    tick();
    imem_ack = 1; imem_rdata = 32'hBAD0_0010; tick(); imem_ack = 0;
    vec_cnt++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'hC || pc !== 32'h100) begin
      err_cnt++; $display("FAIL br_discard got v=%b ifid_pc=%h pc=%h exp 0/c/100", ifid_valid, ifid_pc, pc); end
    tick();
    vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin err_cnt++; $display("FAIL br_next got %b/%h exp 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fetch_one(32'h3000_0000);
    tick();
    exc = 1; br_taken = 1; br_target = 32'h300; imem_ack = 1; tick(); clr_in();
    vec_cnt++; if (pc !== EVEC || ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL simul got pc=%h v=%b exp %h/0", pc, ifid_valid, EVEC); end
    do_reset();
    exc = 1; tick(); exc = 0;
    jmp = 1; jmp_target = 32'h40; tick(); jmp = 0;
    imem_ack = 1; tick(); imem_ack = 0;
    vec_cnt++; if (pc !== EVEC) begin err_cnt++; $display("FAIL exc_sticky got pc=%h exp %h", pc, EVEC); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    jmp = 1; jmp_target = 32'h203; imem_ack = 1; tick(); clr_in();
    vec_cnt++; if (pc !== 32'h200 || misalign !== 1'b1) begin err_cnt++; $display("FAIL mis_pulse got pc=%h mis=%b exp 200/1", pc, misalign); end
    tick();
    vec_cnt++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      err_cnt++; $display("FAIL mis_clear got mis=%b req=%b addr=%h exp 0/1/200", misalign, imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_one(32'h4000_0000);
    tick();
    rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick(); rst = 0; imem_ack = 0;
    vec_cnt++; if (pc !== RVEC || ifid_valid !== 1'b0 || imem_req !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid got pc=%h v=%b req=%b exp %h/0/0", pc, ifid_valid, imem_req, RVEC); end
    tick();
    vec_cnt++; if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_data got %h/%b exp 0/0", ifid_instr, ifid_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      vec_cnt++; if (pc !== m_pc) begin err_cnt++; $display("FAIL rnd_pc @%0d got %h exp %h", c, pc, m_pc); end
      vec_cnt++; if (imem_req !== m_req) begin err_cnt++; $display("FAIL rnd_req @%0d got %b exp %b", c, imem_req, m_req); end
      vec_cnt++; if (imem_req && imem_addr !== m_pc) begin err_cnt++; $display("FAIL rnd_addr @%0d got %h exp %h", c, imem_addr, m_pc); end
      vec_cnt++; if (ifid_valid !== m_iv) begin err_cnt++; $display("FAIL rnd_valid @%0d got %b exp %b", c, ifid_valid, m_iv); end
      vec_cnt++; if (ifid_pc !== m_ipc) begin err_cnt++; $display("FAIL rnd_ifid_pc @%0d got %h exp %h", c, ifid_pc, m_ipc); end
      vec_cnt++; if (ifid_pc4 !== m_ipc4) begin err_cnt++; $display("FAIL rnd_ifid_pc4 @%0d got %h exp %h", c, ifid_pc4, m_ipc4); end
      vec_cnt++; if (ifid_instr !== m_iins) begin err_cnt++; $display("FAIL rnd_instr @%0d got %h exp %h", c, ifid_instr, m_iins); end
      vec_cnt++; if (misalign !== m_mis) begin err_cnt++; $display("FAIL rnd_misalign @%0d got %b exp %b", c, misalign, m_mis); end
      rst        = ($urandom_range(0, 149) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      exc        = ($urandom_range(0, 39) == 0);
      br_taken   = ($urandom_range(0, 14) == 0);
      jmp        = ($urandom_range(0, 14) == 0);
      br_target  = $urandom;
      jmp_target = $urandom;
      imem_ack   = imem_req && ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      tick();
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    @(negedge clk);
    test_reset();
    test_seq_fetch();
    test_stall_on_ack();
    test_branch_wait();
    test_simultaneous();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
